formula_loader: RTL and testbench

- Writer side of the solver's formula interface: accepts a literal-serial stream over a valid/ready handshake and assembles one packed common::formula for the DPLL core.
- Sits between the host/testbench feeder and the solver's formula stack entry.
- Holds the completed formula until the consumer takes it.
- Malformed streams (bad literal index, clause or formula overflow) are drained and flagged, never forwarded.

---
 rtl/formula_loader_pkg.sv | 35 +++
 rtl/formula_loader.sv | 112 +++++++++++
 tb/tb_formula_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/formula_loader_pkg.sv
// Shared formula types for the solver's formula interface, plus loader FSM states.
// Literal = {variable index, polarity}; unused slots are kept zero.
package common;
  localparam int number_literal    = 5;
  localparam int number_clauses    = 10;
  localparam int width_litarray    = 2;
  localparam int width_clausearray = 3;

  typedef struct packed {
    logic [width_litarray:0] num;
    logic                    val;
  } lit;

  typedef lit [number_literal-1:0] lit_array;

  typedef struct packed {
    lit_array                lits;
    logic [width_litarray:0] len;
  } clause;

  typedef clause [number_clauses-1:0] clause_array;

  typedef struct packed {
    clause_array                clauses;
    logic [width_clausearray:0] len;
  } formula;

  localparam formula zero_formula = '0;

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} loader_state_t;

  function automatic logic lit_legal(input logic [width_litarray:0] num);
    return (num != '0) && (32'(num) <= number_literal);
  endfunction
endpackage

// File: rtl/formula_loader.sv
// Assembles a literal-serial stream into one packed formula; f_valid rises 1 cycle after the last beat.
// in_ready drops while a finished formula waits for f_ready; malformed formulas are drained and pulse err.
module formula_loader
  import common::*;
#(
  parameter int NUM_CLAUSES  = number_clauses,
  parameter int NUM_LITERALS = number_literal
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [width_litarray:0] in_num,
  input  logic                    in_val,
  input  logic                    in_last_lit,
  input  logic                    in_last_clause,
  output logic                    f_valid,
  input  logic                    f_ready,
  output formula                  f_out,
  output logic                    err
);
  localparam logic [width_litarray:0]    LIT_MAX = NUM_LITERALS[width_litarray:0];
  localparam logic [width_clausearray:0] CLS_MAX = NUM_CLAUSES[width_clausearray:0];

  loader_state_t              state;
  loader_state_t              state_nx;
  logic [width_litarray:0]    lit_idx;
  logic [width_clausearray:0] cls_idx;
  logic                       accept;
  logic                       beat_end;
  logic                       beat_bad;
  logic                       do_write;
  logic                       do_clear;
  logic                       err_nx;

  assign in_ready = (state != S_DONE);
  assign accept   = in_valid && in_ready;
  assign beat_end = in_last_lit && in_last_clause;
  // Overflow is caught here, before any counter could increment past its slot range.
  assign beat_bad = !lit_legal(in_num) || (lit_idx == LIT_MAX) || (cls_idx == CLS_MAX);

  always_comb begin
    state_nx = state;
    do_write = 1'b0;
    do_clear = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_COLLECT: begin
        if (accept) begin
          if (beat_bad) begin
            if (beat_end) begin
              err_nx   = 1'b1;
              do_clear = 1'b1;
            end else begin
              state_nx = S_DRAIN;
            end
          end else begin
            do_write = 1'b1;
            if (beat_end) state_nx = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (accept && beat_end) begin
          err_nx   = 1'b1;
          do_clear = 1'b1;
          state_nx = S_COLLECT;
        end
      end
      S_DONE: begin
        if (f_valid && f_ready) begin
          do_clear = 1'b1;
          state_nx = S_COLLECT;
        end
      end
      default: begin
        do_clear = 1'b1;
        state_nx = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_COLLECT;
      f_out   <= zero_formula;
      f_valid <= 1'b0;
      err     <= 1'b0;
      lit_idx <= '0;
      cls_idx <= '0;
    end else begin
      state   <= state_nx;
      f_valid <= (state_nx == S_DONE);
      err     <= err_nx;
      if (do_clear) begin
        f_out   <= zero_formula;
        lit_idx <= '0;
        cls_idx <= '0;
      end else if (do_write) begin
        f_out.clauses[cls_idx].lits[lit_idx] <= '{num: in_num, val: in_val};
        f_out.clauses[cls_idx].len           <= lit_idx + 1'b1;
        if (in_last_lit) begin
          lit_idx   <= '0;
          cls_idx   <= cls_idx + 1'b1;
          f_out.len <= cls_idx + 1'b1;
        end else begin
          lit_idx <= lit_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_formula_loader.sv
// Directed and randomized streams checked against a clause-grouping reference model.
module tb_formula_loader;
  import common::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [width_litarray:0] in_num;
  logic                    in_val;
  logic                    in_last_lit;
  logic                    in_last_clause;
  logic                    f_valid;
  logic                    f_ready;
  formula                  f_out;
  logic                    err;

  always #5 clk = ~clk;

  formula_loader #(.NUM_CLAUSES(number_clauses), .NUM_LITERALS(number_literal)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_val(in_val), .in_last_lit(in_last_lit),
    .in_last_clause(in_last_clause), .f_valid(f_valid), .f_ready(f_ready),
    .f_out(f_out), .err(err)
  );

  typedef struct {
    logic [width_litarray:0] num;
    logic                    val;
    logic                    ll;
    logic                    lc;
  } beat_t;

  beat_t  beats[$];
  int     errors  = 0;
  int     checks  = 0;
  int     err_cnt = 0;
  int     fv_cnt  = 0;
  formula got_f;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (f_valid === 1'b1) fv_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [$bits(formula)-1:0] obs,
                     input logic [$bits(formula)-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int num, input bit val, input bit ll, input bit lc);
    beat_t b;
    b.num = 3'(num);
    b.val = val;
    b.ll  = ll;
    b.lc  = lc;
    beats.push_back(b);
  endfunction

  // Group beats into clauses; malformed if any index is illegal, a clause is too long,
  // or there are too many clauses. Otherwise lay the clauses out in slot order.
  function automatic void model(output formula f, output bit bad);
    int lens[$];
    int cur = 0;
    int k   = 0;
    f   = zero_formula;
    bad = 1'b0;
    foreach (beats[i]) begin
      if (beats[i].num < 1 || beats[i].num > number_literal) bad = 1'b1;
      cur++;
      if (beats[i].ll) begin
        lens.push_back(cur);
        cur = 0;
      end
    end
    if (lens.size() > number_clauses) bad = 1'b1;
    foreach (lens[c]) if (lens[c] > number_literal) bad = 1'b1;
    if (!bad) begin
      f.len = 4'(lens.size());
      foreach (lens[c]) begin
        f.clauses[c].len = 3'(lens[c]);
        for (int l = 0; l < lens[c]; l++) begin
          f.clauses[c].lits[l].num = beats[k].num;
          f.clauses[c].lits[l].val = beats[k].val;
          k++;
        end
      end
    end
  endfunction

  task automatic send_beat(input beat_t b);
    int n;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_num         = b.num;
    in_val         = b.val;
    in_last_lit    = b.ll;
    in_last_clause = b.lc;
    in_valid       = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_formula(input string name, input int hold);
    formula ef;
    bit     eb;
    int     e0;
    int     v0;
    model(ef, eb);
    e0 = err_cnt;
    v0 = fv_cnt;
    foreach (beats[i]) send_beat(beats[i]);
    if (eb) begin
      chk({name, "_err_now"}, err, 1);
      chk({name, "_fvalid_low"}, f_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_err_once"}, err_cnt - e0, 1);
      chk({name, "_fvalid_never"}, fv_cnt - v0, 0);
      chk({name, "_fout_zero"}, f_out, zero_formula);
      chk({name, "_ready"}, in_ready, 1);
    end else begin
      chk({name, "_fvalid"}, f_valid, 1);
      chk({name, "_fout"}, f_out, ef);
      chk({name, "_ready_low"}, in_ready, 0);
      got_f = f_out;
      repeat (hold) begin
        in_valid       = 1'b1;
        in_num         = 3'($urandom_range(0, 7));
        in_last_lit    = 1'b1;
        in_last_clause = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_hold_fout"}, f_out, ef);
        chk({name, "_hold_fvalid"}, f_valid, 1);
      end
      in_valid = 1'b0;
      f_ready  = 1'b1;
      @(posedge clk);
      #1;
      f_ready = 1'b0;
      chk({name, "_taken_fvalid"}, f_valid, 0);
      chk({name, "_taken_fout"}, f_out, zero_formula);
      chk({name, "_taken_ready"}, in_ready, 1);
      chk({name, "_no_err"}, err_cnt - e0, 0);
    end
  endtask

  task automatic gen_random(input int mode);
    int ncl;
    int bigc;
    int idx;
    int p;
    beats.delete();
    ncl  = (mode == 3) ? $urandom_range(11, 12) : $urandom_range(1, number_clauses);
    bigc = $urandom_range(0, ncl - 1);
    for (int c = 0; c < ncl; c++) begin
      int nl;
      nl = (mode == 2 && c == bigc) ? $urandom_range(6, 7) : $urandom_range(1, number_literal);
      for (int l = 0; l < nl; l++) begin
        bit ll;
        bit lc;
        ll = (l == nl - 1);
        lc = ll ? (c == ncl - 1) : ($urandom_range(0, 3) == 0);
        push($urandom_range(1, number_literal), 1'($urandom_range(0, 1)), ll, lc);
      end
    end
    if (mode == 1) begin
      idx = $urandom_range(0, beats.size() - 1);
      p   = $urandom_range(0, 2);
      beats[idx].num = (p == 0) ? 3'd0 : ((p == 1) ? 3'd6 : 3'd7);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_num         = '0;
    in_val         = 1'b0;
    in_last_lit    = 1'b0;
    in_last_clause = 1'b0;
    f_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_fvalid", f_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_fout", f_out, zero_formula);

    beats.delete();
    push(1, 1, 0, 0); push(2, 0, 1, 0); push(3, 1, 1, 1);
    run_formula("basic", 5);
    chk("basic_len", got_f.len, 2);
    chk("basic_c0_len", got_f.clauses[0].len, 2);
    chk("basic_c0_l1", got_f.clauses[0].lits[1], {3'd2, 1'b0});
    chk("basic_c1_l0", got_f.clauses[1].lits[0], {3'd3, 1'b1});
    chk("basic_c2_zero", got_f.clauses[2], 0);

    beats.delete();
    for (int i = 1; i <= 6; i++) push((i - 1) % 5 + 1, 1, 0, 0);
    push(2, 1, 1, 0); push(3, 0, 1, 1);
    run_formula("lit_overflow", 0);

    beats.delete();
    push(5, 0, 1, 0); push(4, 1, 0, 0); push(3, 1, 1, 1);
    run_formula("after_drain", 1);

    beats.delete();
    for (int i = 0; i < 11; i++) push(i % 5 + 1, 1'(i & 1), 1, i == 10);
    run_formula("cls_overflow", 0);

    beats.delete();
    push(0, 1, 0, 0); push(2, 1, 1, 1);
    run_formula("num_zero", 0);

    beats.delete();
    push(1, 1, 1, 0); push(6, 0, 1, 1);
    run_formula("num_six", 0);

    beats.delete();
    push(1, 1, 0, 1); push(2, 0, 1, 1);
    run_formula("lc_ignored", 2);

    beats.delete();
    for (int c = 0; c < 10; c++)
      for (int l = 0; l < 5; l++) push((c + l) % 5 + 1, 1'(c ^ l), l == 4, (l == 4) && (c == 9));
    run_formula("full", 1);

    beats.delete();
    push(1, 1, 0, 0); push(2, 1, 1, 0); push(3, 0, 0, 0);
    foreach (beats[i]) send_beat(beats[i]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_fout", f_out, zero_formula);
    chk("midreset_fvalid", f_valid, 0);
    chk("midreset_ready", in_ready, 1);
    chk("midreset_err", err, 0);
    beats.delete();
    push(4, 0, 1, 1);
    run_formula("post_reset", 2);
    chk("post_reset_len", got_f.len, 1);
    chk("post_reset_lit", got_f.clauses[0].lits[0], {3'd4, 1'b0});

    for (int t = 0; t < 24; t++) begin
      gen_random($urandom_range(0, 1) ? 0 : $urandom_range(1, 3));
      run_formula("random", $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
